// File: rtl/gol_pkg.sv
// Shared types for the Game-of-Life generation sequencer.
package gol_pkg;
    localparam int GRID_W = 64;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;

    typedef logic [GRID_W-1:0] grid_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;
endpackage

// File: rtl/gol_tick_div.sv
// Generation pacing counter: counts 0..TICK_DIV-1 while enabled, tick on the last count.
module gol_tick_div #(
    parameter int TICK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = i_en && w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/gol_gen_ctrl.sv
// Generation sequencer: holds the board, steps it through the external datapath,
// and halts on still life, extinction, period-2 oscillation or the generation limit.
module gol_gen_ctrl
    import gol_pkg::*;
#(
    parameter int               GEN_W    = 16,
    parameter logic [GEN_W-1:0] MAX_GEN  = 16'hFFFF,
    parameter int               TICK_DIV = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  grid_t            i_seed,
    input  logic             i_load,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_step,
    input  grid_t            i_grid_evolve,
    output grid_t            o_grid,
    output logic [GEN_W-1:0] o_gen_count,
    output logic             o_gen_tick,
    output logic             o_running,
    output logic             o_halted,
    output logic             o_stable,
    output logic             o_extinct,
    output logic             o_osc2,
    output logic             o_maxed
);
    state_t           r_state, w_state_n;
    grid_t            r_grid, w_grid_n;
    grid_t            r_prev, w_prev_n;
    logic [GEN_W-1:0] r_gen, w_gen_n, w_gen_inc;
    logic             r_gtick, w_gtick_n;
    logic             r_stable, r_extinct, r_osc2, r_maxed;
    logic             w_stable_n, w_extinct_n, w_osc2_n, w_maxed_n;
    logic             w_clr, w_en, w_tick, w_eval;

    gol_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_tick  (w_tick)
    );

    assign w_gen_inc = r_gen + GEN_W'(1);

    always_comb begin
        w_state_n   = r_state;
        w_grid_n    = r_grid;
        w_prev_n    = r_prev;
        w_gen_n     = r_gen;
        w_gtick_n   = 1'b0;
        w_stable_n  = r_stable;
        w_extinct_n = r_extinct;
        w_osc2_n    = r_osc2;
        w_maxed_n   = r_maxed;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_eval      = 1'b0;

        if (i_load) begin
            w_state_n   = IDLE;
            w_grid_n    = i_seed;
            w_prev_n    = i_seed;
            w_gen_n     = '0;
            w_stable_n  = 1'b0;
            w_extinct_n = 1'b0;
            w_osc2_n    = 1'b0;
            w_maxed_n   = 1'b0;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    // stop outranks start/step even though it has no effect of its own here
                    if (!i_stop && i_start) begin
                        w_state_n = RUN;
                        w_clr     = 1'b1;
                    end else if (!i_stop && i_step) begin
                        w_eval = 1'b1;
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        w_state_n = IDLE;
                        w_clr     = 1'b1;
                    end else begin
                        w_en   = 1'b1;
                        w_eval = w_tick;
                    end
                end
                default: ;
            endcase
        end

        if (w_eval) begin
            if (i_grid_evolve == r_grid) begin
                w_stable_n = 1'b1;
                w_state_n  = HALT;
            end else begin
                w_prev_n  = r_grid;
                w_grid_n  = i_grid_evolve;
                w_gen_n   = w_gen_inc;
                w_gtick_n = 1'b1;
                if (i_grid_evolve == '0) begin
                    w_extinct_n = 1'b1;
                    w_state_n   = HALT;
                end else if (i_grid_evolve == r_prev && r_gen != '0) begin
                    w_osc2_n  = 1'b1;
                    w_state_n = HALT;
                end
                if (w_gen_inc == MAX_GEN) begin
                    w_maxed_n = 1'b1;
                    w_state_n = HALT;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_grid    <= '0;
            r_prev    <= '0;
            r_gen     <= '0;
            r_gtick   <= 1'b0;
            r_stable  <= 1'b0;
            r_extinct <= 1'b0;
            r_osc2    <= 1'b0;
            r_maxed   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_grid    <= w_grid_n;
            r_prev    <= w_prev_n;
            r_gen     <= w_gen_n;
            r_gtick   <= w_gtick_n;
            r_stable  <= w_stable_n;
            r_extinct <= w_extinct_n;
            r_osc2    <= w_osc2_n;
            r_maxed   <= w_maxed_n;
        end
    end

    assign o_grid      = r_grid;
    assign o_gen_count = r_gen;
    assign o_gen_tick  = r_gtick;
    assign o_running   = (r_state == RUN);
    assign o_halted    = (r_state == HALT);
    assign o_stable    = r_stable;
    assign o_extinct   = r_extinct;
    assign o_osc2      = r_osc2;
    assign o_maxed     = r_maxed;
endmodule

// File: tb/tb_gol_gen_ctrl.sv
// Bench for gol_gen_ctrl: three instances (default, TICK_DIV=4, MAX_GEN=3) each fed by a Life model.
module tb_gol_gen_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] seed = '0;
    logic        ld = 1'b0, st = 1'b0, sp = 1'b0, stp = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] life(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                            cnt += int'(g[(r + dr) * 8 + (c + dc)]);
                n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // instance A: defaults
    logic [63:0] a_grid;  logic [15:0] a_gen;
    logic a_gt, a_run, a_hal, a_stb, a_ext, a_osc, a_max;
    logic [63:0] a_evo;
    assign a_evo = life(a_grid);
    gol_gen_ctrl u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_seed(seed), .i_load(ld), .i_start(st), .i_stop(sp),
        .i_step(stp), .i_grid_evolve(a_evo), .o_grid(a_grid), .o_gen_count(a_gen),
        .o_gen_tick(a_gt), .o_running(a_run), .o_halted(a_hal), .o_stable(a_stb),
        .o_extinct(a_ext), .o_osc2(a_osc), .o_maxed(a_max));

    // instance B: TICK_DIV=4
    logic [63:0] b_grid;  logic [15:0] b_gen;
    logic b_gt, b_run, b_hal, b_stb, b_ext, b_osc, b_max;
    logic [63:0] b_evo;
    assign b_evo = life(b_grid);
    gol_gen_ctrl #(.TICK_DIV(4)) u_div4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_seed(seed), .i_load(ld), .i_start(st), .i_stop(sp),
        .i_step(stp), .i_grid_evolve(b_evo), .o_grid(b_grid), .o_gen_count(b_gen),
        .o_gen_tick(b_gt), .o_running(b_run), .o_halted(b_hal), .o_stable(b_stb),
        .o_extinct(b_ext), .o_osc2(b_osc), .o_maxed(b_max));

    // instance C: MAX_GEN=3
    logic [63:0] c_grid;  logic [15:0] c_gen;
    logic c_gt, c_run, c_hal, c_stb, c_ext, c_osc, c_max;
    logic [63:0] c_evo;
    assign c_evo = life(c_grid);
    gol_gen_ctrl #(.MAX_GEN(16'd3)) u_max (
        .i_clk(clk), .i_rst_n(rst_n), .i_seed(seed), .i_load(ld), .i_start(st), .i_stop(sp),
        .i_step(stp), .i_grid_evolve(c_evo), .o_grid(c_grid), .o_gen_count(c_gen),
        .o_gen_tick(c_gt), .o_running(c_run), .o_halted(c_hal), .o_stable(c_stb),
        .o_extinct(c_ext), .o_osc2(c_osc), .o_maxed(c_max));

    // status order: gen_tick running halted stable extinct osc2 maxed
    logic [6:0] a_stat, b_stat, c_stat;
    assign a_stat = {a_gt, a_run, a_hal, a_stb, a_ext, a_osc, a_max};
    assign b_stat = {b_gt, b_run, b_hal, b_stb, b_ext, b_osc, b_max};
    assign c_stat = {c_gt, c_run, c_hal, c_stb, c_ext, c_osc, c_max};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ld, st, sp, stp;
        logic [63:0] seed;
        logic [63:0] e_grid;
        logic [15:0] e_gen;
        logic [6:0]  e_stat;
    } vec_t;

    localparam logic [63:0] T1  = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] BLH = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLV = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLK = 64'h0000_0018_1800_0000;
    localparam logic [63:0] ONE = 64'h0000_0000_0800_0000;
    localparam logic [63:0] GLD = 64'h0000_0000_0007_0402;

    vec_t vecs[18];
    logic [63:0] g3;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, BLH, BLH, 16'd0, 7'b0000000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, '0,  BLH, 16'd0, 7'b0100000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, '0,  BLV, 16'd1, 7'b1100000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, '0,  BLH, 16'd2, 7'b1010010};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, '0,  BLH, 16'd2, 7'b0010010};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, BLK, BLK, 16'd0, 7'b0000000};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, '0,  BLK, 16'd0, 7'b0100000};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, '0,  BLK, 16'd0, 7'b0011000};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, ONE, ONE, 16'd0, 7'b0000000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,  '0,  16'd1, 7'b1010100};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, '0,  '0,  16'd1, 7'b0010100};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, '0,  '0,  16'd1, 7'b0010100};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, BLH, BLH, 16'd0, 7'b0000000};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, '0,  BLH, 16'd0, 7'b0100000};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, '0,  BLH, 16'd0, 7'b0000000};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, '0,  '0,  16'd0, 7'b0000000};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, '0,  '0,  16'd0, 7'b0011000};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, '0,  '0,  16'd0, 7'b0011000};

        // reset, seed load, asynchronous reset mid-RUN
        tick(); tick();
        chk("reset_grid", a_grid, 64'h0);
        chk("reset_stat", {57'h0, a_stat}, 64'h0);
        rst_n = 1'b1;
        ld = 1'b1; seed = T1; tick(); ld = 1'b0;
        chk("load_grid", a_grid, T1);
        chk("load_gen", {48'h0, a_gen}, 64'h0);
        chk("load_stat", {57'h0, a_stat}, 64'h0);
        seed = GLD; ld = 1'b1; tick(); ld = 1'b0;
        st = 1'b1; tick(); st = 1'b0;
        tick();
        chk("prereset_running", {63'h0, a_run}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_grid", a_grid, 64'h0);
        chk("async_gen", {48'h0, a_gen}, 64'h0);
        chk("async_stat", {57'h0, a_stat}, 64'h0);
        chk("async_stat_div4", {57'h0, b_stat}, 64'h0);
        #1 rst_n = 1'b1;
        tick();

        // table-driven: blinker, block, extinction, priorities, empty seed
        for (int i = 0; i < 18; i++) begin
            ld = vecs[i].ld; st = vecs[i].st; sp = vecs[i].sp; stp = vecs[i].stp; seed = vecs[i].seed;
            tick();
            ld = 1'b0; st = 1'b0; sp = 1'b0; stp = 1'b0;
            chk($sformatf("vec%0d_grid", i), a_grid, vecs[i].e_grid);
            chk($sformatf("vec%0d_gen", i), {48'h0, a_gen}, {48'h0, vecs[i].e_gen});
            chk($sformatf("vec%0d_stat", i), {57'h0, a_stat}, {57'h0, vecs[i].e_stat});
        end

        // pacing with TICK_DIV=4, stop mid-count, restart, start+step
        g3 = life(life(life(GLD)));
        seed = GLD; ld = 1'b1; tick(); ld = 1'b0;
        st = 1'b1; tick(); st = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("div4_gtick_c%0d", i), {63'h0, b_gt}, {63'h0, (i % 4 == 0)});
        end
        chk("div4_gen3", {48'h0, b_gen}, 64'd3);
        chk("div4_grid3", b_grid, g3);
        tick(); tick();
        sp = 1'b1; tick(); sp = 1'b0;
        chk("div4_stop_running", {63'h0, b_run}, 64'h0);
        chk("div4_stop_gen", {48'h0, b_gen}, 64'd3);
        chk("div4_stop_grid", b_grid, g3);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("div4_idle_gtick_c%0d", i), {63'h0, b_gt}, 64'h0);
        end
        st = 1'b1; stp = 1'b1; tick(); st = 1'b0; stp = 1'b0;
        chk("div4_startstep_running", {63'h0, b_run}, 64'h1);
        chk("div4_startstep_gen", {48'h0, b_gen}, 64'd3);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("div4_restart_gtick_c%0d", i), {63'h0, b_gt}, {63'h0, (i == 4)});
            chk($sformatf("div4_restart_gen_c%0d", i), {48'h0, b_gen}, (i == 4) ? 64'd4 : 64'd3);
        end

        // generation limit MAX_GEN=3, then load+stop
        seed = GLD; ld = 1'b1; tick(); ld = 1'b0;
        st = 1'b1; tick(); st = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("max_gen_c%0d", i), {48'h0, c_gen}, 64'(i));
        end
        chk("max_stat", {57'h0, c_stat}, {57'h0, 7'b1010001});
        tick();
        chk("max_frozen_gen", {48'h0, c_gen}, 64'd3);
        chk("max_frozen_stat", {57'h0, c_stat}, {57'h0, 7'b0010001});
        ld = 1'b1; sp = 1'b1; seed = GLD; tick(); ld = 1'b0; sp = 1'b0;
        chk("loadstop_stat", {57'h0, c_stat}, 64'h0);
        chk("loadstop_gen", {48'h0, c_gen}, 64'h0);
        chk("loadstop_grid", c_grid, GLD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
